// File: rtl/nrad_pkg.sv
// Shared types for the sequential non-restoring divider: FSM encoding,
// default operand widths and the iteration-counter width helper.
package nrad_pkg;

  localparam int DW_DEF = 4;
  localparam int VW_DEF = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Counter must reach DW-1; a single bit is kept for the degenerate DW==1 case.
  function automatic int cnt_width(input int dw);
    return (dw > 1) ? $clog2(dw) : 1;
  endfunction

endpackage

// File: rtl/nrad_seq_ctrl_if.sv
// Request/response bundle of the sequential divider: the requester drives
// start/X/Y, the divider returns busy/done and the held Q/R/div_zero result.
interface nrad_seq_ctrl_if #(
  parameter int DW = 4,
  parameter int VW = 2
);

  logic          start;
  logic [DW-1:0] X;
  logic [VW-1:0] Y;
  logic          busy;
  logic          done;
  logic [DW-1:0] Q;
  logic [VW-1:0] R;
  logic          div_zero;

  modport master (
    output start, X, Y,
    input  busy, done, Q, R, div_zero
  );

  modport slave (
    input  start, X, Y,
    output busy, done, Q, R, div_zero
  );

endinterface

// File: rtl/nrad_addsub_cell.sv
// Single signed add/subtract stage shared by the iterate and correction steps.
// sum carries the low W-1 result bits (the next partial remainder), sign the MSB.
module nrad_addsub_cell #(
  parameter int W = 4
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic                sub,
  output logic signed [W-2:0] sum,
  output logic                sign
);

  logic signed [W-1:0] res;

  assign res  = sub ? (a - b) : (a + b);
  assign sum  = res[W-2:0];
  assign sign = res[W-1];

endmodule

// File: rtl/nrad_seq_ctrl.sv
// Sequential non-restoring divider: one add/sub cell reused over DW iterations
// plus a remainder fix-up. Optional macro NRAD_EARLY_DONE_EN short-cuts X<Y.
module nrad_seq_ctrl
  import nrad_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  nrad_seq_ctrl_if.slave    bus
);

  localparam int CW = cnt_width(DW);
  localparam int PW = VW + 1;
  localparam int TW = VW + 2;

  state_t              state;
  state_t              state_nx;
  logic [CW-1:0]       cnt;
  logic [DW-1:0]       a_q;
  logic signed [PW-1:0] p_q;
  logic [VW-1:0]       d_q;

  logic                done_q;
  logic [DW-1:0]       q_q;
  logic [VW-1:0]       r_q;
  logic                dz_q;

  logic                accept;
  logic                iter_last;
  logic                zero_div;
  logic                early;

  logic signed [TW-1:0] cell_a;
  logic signed [TW-1:0] cell_b;
  logic                 cell_sub;
  logic signed [PW-1:0] cell_sum;
  logic                 cell_sign;

  assign accept    = (state == S_IDLE) && bus.start;
  assign iter_last = (cnt == CW'(DW - 1));
  assign zero_div  = (bus.Y == '0);

`ifdef NRAD_EARLY_DONE_EN
  assign early = !zero_div && (bus.X < DW'(bus.Y));
`else
  assign early = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and cell operand selection
  always_comb begin
    state_nx = state;
    cell_a   = {p_q, a_q[DW-1]};
    cell_b   = $signed({2'b00, d_q});
    cell_sub = ~p_q[PW-1];
    case (state)
      S_IDLE: begin
        if (bus.start) state_nx = (zero_div || early) ? S_DONE : S_ITER;
      end
      S_ITER: begin
        if (iter_last) state_nx = S_FIX;
      end
      S_FIX: begin
        cell_a   = {p_q[PW-1], p_q};
        cell_sub = 1'b0;
        state_nx = S_DONE;
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  nrad_addsub_cell #(.W(TW)) u_cell (
    .a    (cell_a),
    .b    (cell_b),
    .sub  (cell_sub),
    .sum  (cell_sum),
    .sign (cell_sign)
  );

  // Control, counter and held results
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      done_q <= 1'b0;
      q_q    <= '0;
      r_q    <= '0;
      dz_q   <= 1'b0;
    end else begin
      done_q <= (state == S_DONE);
      if (accept) begin
        cnt  <= '0;
        dz_q <= 1'b0;
      end else if (state == S_ITER) begin
        cnt <= cnt + CW'(1);
      end
      if (state == S_DONE) begin
        q_q  <= a_q;
        r_q  <= p_q[VW-1:0];
        dz_q <= (d_q == '0);
      end
    end
  end

  // Operand/partial-remainder datapath; short-cut paths preload the final Q/R.
  always_ff @(posedge clk) begin
    if (accept) begin
      d_q <= bus.Y;
      if (zero_div) begin
        a_q <= '1;
        p_q <= '0;
      end else if (early) begin
        a_q <= '0;
        p_q <= $signed({1'b0, bus.X[VW-1:0]});
      end else begin
        a_q <= bus.X;
        p_q <= '0;
      end
    end else if (state == S_ITER) begin
      p_q <= cell_sum;
      a_q <= {a_q[DW-2:0], ~cell_sign};
    end else if ((state == S_FIX) && p_q[PW-1]) begin
      p_q <= cell_sum;
    end
  end

  assign bus.busy     = (state != S_IDLE);
  assign bus.done     = done_q;
  assign bus.Q        = q_q;
  assign bus.R        = r_q;
  assign bus.div_zero = dz_q;

endmodule

// File: tb/tb_nrad_seq_ctrl.sv
// Self-checking bench for nrad_seq_ctrl: directed scenarios plus randomized
// back-to-back divides checked against an arithmetic reference model.
module tb_nrad_seq_ctrl;

  localparam int DW = 4;
  localparam int VW = 2;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  nrad_seq_ctrl_if #(.DW(DW), .VW(VW)) bus ();

  nrad_seq_ctrl #(.DW(DW), .VW(VW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer division; latency counted in edges after accept.
  task automatic ref_div(input int x, input int y, output logic [DW-1:0] q,
                         output logic [VW-1:0] r, output logic dz, output int lat);
    if (y == 0) begin
      q = '1; r = '0; dz = 1'b1; lat = 1;
    end else begin
      q = DW'(x / y); r = VW'(x % y); dz = 1'b0; lat = DW + 2;
`ifdef NRAD_EARLY_DONE_EN
      if (x < y) lat = 1;
`endif
    end
  endtask

  task automatic do_div(input int x, input int y, input string nm);
    logic [DW-1:0] eq;
    logic [VW-1:0] er;
    logic          ez;
    int            lat;
    int            n;
    ref_div(x, y, eq, er, ez, lat);
    bus.start = 1'b1;
    bus.X     = DW'(x);
    bus.Y     = VW'(y);
    step();
    bus.start = 1'b0;
    bus.X     = DW'($urandom);
    bus.Y     = VW'($urandom);
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL %s done_width: done=%b required 0 after accept", nm, bus.done);
    end
    n = 0;
    while (bus.done !== 1'b1 && n < 20) begin
      checks++;
      if (bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL %s busy: busy=%b at edge %0d required 1", nm, bus.busy, n);
      end
      step();
      n++;
    end
    checks++;
    if (n != lat) begin
      errors++;
      $display("FAIL %s latency: done after edge %0d required %0d", nm, n, lat);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.Q !== eq || bus.R !== er || bus.div_zero !== ez) begin
      errors++;
      $display("FAIL %s result X=%0d Y=%0d: busy=%b Q=%0d R=%0d dz=%b required busy=0 Q=%0d R=%0d dz=%b",
               nm, x, y, bus.busy, bus.Q, bus.R, bus.div_zero, eq, er, ez);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0; bus.X = '0; bus.Y = '0;
    step(); step();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.Q !== '0 || bus.R !== '0 ||
        bus.div_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b Q=%0d R=%0d dz=%b required all 0",
               bus.busy, bus.done, bus.Q, bus.R, bus.div_zero);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    do_div(13, 3, "basic_13_3");
    do_div(15, 2, "basic_15_2");
    do_div(0, 1, "basic_0_1");
  endtask

  task automatic test_div_zero();
    do_div(9, 0, "divzero_9_0");
    do_div(15, 1, "after_divzero_15_1");
  endtask

  task automatic test_ignore_start();
    int            dones;
    logic [DW-1:0] qv;
    logic [VW-1:0] rv;
    dones = 0; qv = '0; rv = '0;
    bus.start = 1'b1; bus.X = DW'(10); bus.Y = VW'(3);
    step();
    bus.start = 1'b0;
    step(); step();
    bus.start = 1'b1; bus.X = DW'(7); bus.Y = VW'(2);
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (bus.done === 1'b1) begin
        dones++; qv = bus.Q; rv = bus.R;
      end
      step();
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL ignore_start_dones: got %0d pulses required 1", dones);
    end
    checks++;
    if (qv !== DW'(10 / 3) || rv !== VW'(10 % 3)) begin
      errors++;
      $display("FAIL ignore_start_result: Q=%0d R=%0d required Q=3 R=1", qv, rv);
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    dones = 0;
    bus.start = 1'b1; bus.X = DW'(14); bus.Y = VW'(3);
    step();
    bus.start = 1'b0;
    step(); step();
    reset = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.Q !== '0 || bus.R !== '0) begin
      errors++;
      $display("FAIL reset_mid_state: busy=%b done=%b Q=%0d R=%0d required all 0",
               bus.busy, bus.done, bus.Q, bus.R);
    end
    step();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.done === 1'b1) dones++;
      step();
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL reset_mid_no_done: got %0d pulses required 0", dones);
    end
    do_div(6, 2, "after_reset_6_2");
  endtask

  task automatic test_early();
    do_div(1, 3, "early_1_3");
    do_div(2, 3, "early_2_3");
  endtask

  task automatic test_back_to_back();
    for (int x = 0; x < 16; x++) begin
      for (int y = 1; y < 4; y++) begin
        do_div(x, y, "sweep");
      end
    end
    for (int i = 0; i < 30; i++) begin
      do_div(int'($urandom_range(15, 0)), int'($urandom_range(3, 0)), "random");
    end
    step();
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL final_done_width: done=%b required 0", bus.done);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_div_zero();
    test_ignore_start();
    test_reset_mid();
    test_early();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
